// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: issues one imem read at a time and buffers {pc, instruction}
// pairs for ID behind a valid/ready handshake. It also drives the PC stall and handles flush.
module instruction_fetch_queue #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        chip_enable,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        stall_request,
  output logic        imem_request,
  output logic [31:0] imem_address,
  input  logic        imem_grant,
  input  logic        imem_response_valid,
  input  logic [31:0] imem_response_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instruction
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t          state, next_state;
  entry_t          fifo [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic [31:0]     pending_pc;
  logic            push, pop, take;

  assign imem_request  = (state == IDLE) && chip_enable && !flush && (count < DEPTH_C);
  assign imem_address  = {pc[31:2], 2'b00};
  assign take          = imem_request && imem_grant;
  // PC moves only when its fetch is accepted; never held across a redirect
  assign stall_request = chip_enable && !flush && !take;

  assign push = (state == WAIT) && imem_response_valid && !flush;
  assign pop  = id_valid && id_ready;

  assign id_pc          = fifo[rd_ptr].pc;
  assign id_instruction = fifo[rd_ptr].instr;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (take) next_state = WAIT;
      WAIT:    if (imem_response_valid) next_state = IDLE;
               else if (flush)          next_state = DROP;
      DROP:    if (imem_response_valid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      pending_pc <= '0;
      id_valid   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else begin
      state <= next_state;
      if (take) pending_pc <= pc;
      if (flush) begin
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        id_valid <= 1'b0;
      end else begin
        if (push) begin
          assert (count != DEPTH_C);
          fifo[wr_ptr] <= '{pc: pending_pc, instr: imem_response_data};
          wr_ptr       <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        count    <= count_nxt;
        id_valid <= (count_nxt != '0);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Randomized bench for instruction_fetch_queue: a transaction-level model predicts
// fetch acceptance and the {pc, instruction} stream; a negedge monitor scores ID beats.
module tb_instruction_fetch_queue;

  localparam int DEPTH = 2;

  logic        clock, reset, chip_enable, flush;
  logic [31:0] pc;
  logic        stall_request, imem_request, imem_grant;
  logic [31:0] imem_address;
  logic        imem_response_valid;
  logic [31:0] imem_response_data;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_instruction;

  instruction_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .chip_enable(chip_enable), .pc(pc), .flush(flush),
    .stall_request(stall_request), .imem_request(imem_request), .imem_address(imem_address),
    .imem_grant(imem_grant), .imem_response_valid(imem_response_valid),
    .imem_response_data(imem_response_data), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instruction(id_instruction)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  bit mon_en = 0;

  // reference model: expected queue contents and the single outstanding fetch
  logic [63:0] exp_q [$];
  bit          out_valid = 0, out_live = 0, acc_prev = 0;
  logic [31:0] out_pc = '0, redir = '0;
  int          lat_cnt = 0;

  int ce_pct = 100, fl_pct = 0, gr_pct = 100, rd_pct = 100, lat_min = 0, lat_max = 0;
  bit fixed_redir = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit roll(input int pct);
    return ($urandom % 100) < pct;
  endfunction

  // one clock: commit the edge just taken into the model, drive new inputs, check fetch side
  task automatic step(input bit rst_v, input bit fl_force, input bit stray);
    bit exp_req;
    @(posedge clock);
    #2;
    if (!reset) begin
      exp_q.delete();
      out_valid = 0;
      pc = '0;
    end else begin
      if (flush) begin
        exp_q.delete();
        if (imem_response_valid) out_valid = 0;
        else out_live = 0;
        pc = redir;
      end else if (imem_response_valid && out_valid) begin
        if (out_live) exp_q.push_back({out_pc, imem_response_data});
        out_valid = 0;
      end
      if (acc_prev) begin
        out_valid = 1;
        out_live  = 1;
        out_pc    = pc;
        lat_cnt   = $urandom_range(lat_max, lat_min);
        pc        = pc + 32'd4;
      end
    end

    reset       = rst_v;
    chip_enable = roll(ce_pct);
    flush       = fl_force || roll(fl_pct);
    imem_grant  = roll(gr_pct);
    id_ready    = roll(rd_pct);
    if (flush) redir = fixed_redir ? 32'h100 : $urandom;
    imem_response_data = $urandom;
    if (stray) imem_response_valid = 1'b1;
    else if (out_valid && lat_cnt == 0) imem_response_valid = 1'b1;
    else begin
      imem_response_valid = 1'b0;
      if (out_valid) lat_cnt--;
    end

    #1;
    exp_req = !out_valid && chip_enable && !flush && (exp_q.size() < DEPTH);
    chk("imem_request", imem_request, exp_req);
    chk("imem_address", imem_address, {pc[31:2], 2'b00});
    chk("stall_request", stall_request, chip_enable && !flush && !(exp_req && imem_grant));
    acc_prev = exp_req && imem_grant;
  endtask

  // monitor: scores every ID beat the DUT presents against the expected stream
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en) begin
        chk("id_valid", id_valid, exp_q.size() != 0);
        if (id_valid && id_ready && !flush && reset) begin
          if (exp_q.size() == 0) chk("id_beat_unexpected", {id_pc, id_instruction}, 64'h0);
          else chk("id_beat", {id_pc, id_instruction}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 0; chip_enable = 0; flush = 0; pc = '0; imem_grant = 0;
    imem_response_valid = 0; imem_response_data = '0; id_ready = 0;

    step(0, 0, 0);
    step(0, 0, 0);
    mon_en = 1;
    chk("reset_id_valid", id_valid, 0);
    chk("reset_id_pc", id_pc, 0);
    chk("reset_id_instruction", id_instruction, 0);

    // streaming with single-cycle memory and ID always ready
    for (int i = 0; i < 12; i++) step(1, 0, 0);

    // ID backpressure fills the queue, then a single pop
    rd_pct = 0;
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    chk("full_stall", stall_request, 1);
    rd_pct = 100; step(1, 0, 0);
    rd_pct = 0;   for (int i = 0; i < 4; i++) step(1, 0, 0);
    rd_pct = 100; for (int i = 0; i < 6; i++) step(1, 0, 0);

    // grant withheld
    gr_pct = 0;   for (int i = 0; i < 4; i++) step(1, 0, 0);
    gr_pct = 100; for (int i = 0; i < 4; i++) step(1, 0, 0);

    // flush while waiting on a slow response
    lat_min = 2; lat_max = 2; fixed_redir = 1;
    for (int k = 0; k < 8 && !out_valid; k++) step(1, 0, 0);
    step(1, 1, 0);
    chk("flush_cycle_stall", stall_request, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0);

    // flush coincident with the response
    lat_min = 0; lat_max = 0;
    for (int k = 0; k < 8 && !(out_valid && lat_cnt == 0); k++) step(1, 0, 0);
    step(1, 1, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0);

    // reset mid-wait, then a stray response
    lat_min = 2; lat_max = 2;
    for (int k = 0; k < 8 && !out_valid; k++) step(1, 0, 0);
    step(0, 0, 0);
    ce_pct = 0;
    step(1, 0, 1);
    step(1, 0, 0);
    chk("stray_ignored", id_valid, 0);
    ce_pct = 100;
    step(1, 0, 0);
    chk("first_fetch_pc", imem_address, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0);

    // randomized blocks
    fixed_redir = 0;
    for (int b = 0; b < 15; b++) begin
      ce_pct  = $urandom_range(100, 50);
      fl_pct  = $urandom_range(15, 0);
      gr_pct  = $urandom_range(100, 20);
      rd_pct  = $urandom_range(100, 10);
      lat_min = 0;
      lat_max = $urandom_range(3, 0);
      for (int i = 0; i < 200; i++) step(($urandom % 150) != 0, 0, 0);
    end

    ce_pct = 0; fl_pct = 0; rd_pct = 100; gr_pct = 100;
    for (int i = 0; i < 8; i++) step(1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
- Sits directly downstream of the IF program-counter stage, between that stage, instruction memory and the ID stage.
- Takes the current PC and issues one instruction-memory read at a time over a request/grant and response handshake.
- Buffers returned {pc, instruction} pairs in a small FIFO and presents them to ID with a valid/ready handshake.
- Drives the stall request that holds the PC, and discards in-flight fetches on a pipeline flush.

Parameters:
- DEPTH, 2, number of FIFO entries; must be a power of two and ≥ 2.

Ports:
- clock  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset; sampled at posedge, 0 = reset
- chip_enable  input  1  IF chip enable; no requests are issued while 0
- pc  input  32  current PC from the IF stage
- flush  input  1  branch/jump redirect or exception; kills queued and in-flight fetches
- stall_request  output  1  1 = hold the PC this cycle (combinational)
- imem_request  output  1  read request to instruction memory
- imem_address  output  32  word-aligned read address
- imem_grant  input  1  memory accepts the request this cycle
- imem_response_valid  input  1  read data valid
- imem_response_data  input  32  read data
- id_valid  output  1  head entry valid toward ID
- id_ready  input  1  ID consumes the head entry
- id_pc  output  32  PC of the head entry
- id_instruction  output  32  instruction of the head entry

Behaviour:
- Reset (reset == 0 at posedge):
  - state IDLE; count 0; read/write pointers 0; pending_pc 0.
  - id_valid 0; id_pc and id_instruction 0; all FIFO storage cleared.
  - A response arriving after reset while in IDLE is ignored.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one request granted, response pending.
  - DROP: flushed while pending; the response must be swallowed.
- imem_request = (state == IDLE) && chip_enable && !flush && (count < DEPTH).
- imem_address = {pc[31:2], 2'b00}.
- stall_request = chip_enable && !flush && !(imem_request && imem_grant). The PC advances only in the cycle its fetch is accepted, and is never stalled during flush so the redirect target loads.
- IDLE: on imem_request && imem_grant, latch pending_pc = pc and go to WAIT. Otherwise stay in IDLE.
- WAIT:
  - response_valid && !flush: push {pending_pc, data} and go to IDLE.
  - flush && response_valid: discard the data and go to IDLE.
  - flush && !response_valid: go to DROP.
  - otherwise: stay in WAIT.
- DROP: response_valid discards the data and goes to IDLE. No requests are issued in DROP; a flush in DROP stays in DROP.
- Only one request is outstanding at a time. The earliest next request is the cycle after a response, so best-case throughput is one instruction per 2 cycles (single-cycle memory).
- FIFO:
  - push at the write pointer; pop when id_valid && id_ready; pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - Overflow cannot occur because a request needs a free slot and there is at most one outstanding. A push when count == DEPTH is an assertion failure.
- ID outputs:
  - id_valid = (count != 0), registered.
  - id_pc and id_instruction come from the head entry.
  - Latency is response cycle t → id_valid at t+1; there is no combinational bypass.
  - id_pc and id_instruction are held stable while id_valid && !id_ready.
- Flush:
  - At the next edge, count and pointers go to 0 and id_valid goes to 0.
  - flush overrides push and pop in the same cycle.
  - No request is issued in the flush cycle.
- chip_enable low: no new requests and stall_request 0. An outstanding WAIT still completes and pushes. The FIFO still drains.

Test Plan:
- Reset, then release with pc=0x0, grant=1, 1-cycle responses 0x11111111, 0x22222222, id_ready=1 → id_pc 0x0 then 0x4, instructions matching, a valid beat every 2 cycles, stall_request=0 exactly in the grant cycles.
- Hold id_ready=0 with DEPTH=2 → after 2 pushes imem_request=0 and stall_request=1; pc held at 0x8. Then id_ready=1 for one cycle → one pop and a new request for 0x8 the following cycle.
- grant=0 for 3 cycles with a request pending → imem_request held, imem_address stable, stall_request=1 throughout, PC not advanced.
- Flush while WAIT with the response 2 cycles later → state DROP, late data not pushed, FIFO empty, id_valid=0. Next request uses the redirect pc (e.g. 0x100), with stall_request=0 in the flush cycle.
- Flush coincident with response_valid and with id_ready → nothing pushed, id_valid=0 next cycle, state IDLE.
- Assert reset mid-WAIT, then deliver a stray response → ignored, count stays 0, first post-reset fetch is pc=0x0.
